vmem_ahb_slave: RTL
===================

# vmem_ahb_slave

AHB-Lite subordinate wrapping a word-organised SRAM array, used as vector data memory for the vector core's load/store unit and scalar bus masters. It accepts single transfers with a configurable number of wait states, supports byte/halfword/word writes, and returns a two-cycle ERROR response for misaligned or out-of-range accesses. It sits on the data bus opposite the LSU's AHB master port.

## Interface
- DATA_WIDTH, 32: bus and memory word width.
- MEM_WORDS, 1024: array depth in words (power of two).
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_STATES, 1: extra data-phase cycles per OKAY transfer (0..7).

Ports:
- clk_i  in  1  clock, rising edge.
- resetn_i  in  1  reset, asynchronous, active-low.
- hsel_i  in  1  slave select.
- haddr_i  in  DATA_WIDTH  byte address.
- htrans_i  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite_i  in  1  1 = write.
- hsize_i  in  3  000 byte, 001 halfword, 010 or 011 full word.
- hwdata_i  in  DATA_WIDTH  write data, valid in data phase.
- hrdata_o  out  DATA_WIDTH  read data.
- hready_o  out  1  transfer done / slave ready.
- hresp_o  out  2  OKAY=00, ERROR=01.

## Operation
- Address phase is accepted when hsel_i && htrans_i[1] && hready_o; haddr, hwrite, hsize are registered then. IDLE/BUSY or hsel_i=0 → no transfer, OKAY zero-wait.
- Decode at accept: offset = haddr_i − BASE_ADDR; error if offset ≥ MEM_WORDS*4, or halfword with haddr[0]≠0, or word (010/011) with haddr[1:0]≠0. Word index = offset[.. :2].
- State machine (ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2):
  - ST_IDLE: on accepted good transfer → ST_WAIT if WAIT_STATES>0 else ST_DATA; bad → ST_ERR1; else stay.
  - ST_WAIT: wait counter loaded with WAIT_STATES−1, decrements each cycle; at 0 → ST_DATA. hready_o=0, hresp_o=OKAY.
  - ST_DATA: hready_o=1, OKAY. Write commits this cycle's hwdata_i at the closing edge; read drives mem[index] on hrdata_o. A new transfer accepted in this cycle is decoded as in ST_IDLE (pipelined back-to-back); otherwise → ST_IDLE.
  - ST_ERR1: hready_o=0, hresp_o=ERROR; → ST_ERR2.
  - ST_ERR2: hready_o=1, hresp_o=ERROR; no memory access; new transfer may be accepted as in ST_IDLE.
- Byte strobes: byte → lane haddr[1:0]; halfword → lanes {haddr[1],0},{haddr[1],1}; word → all four. Unselected bytes unchanged. hwdata_i lanes are in natural positions (no replication required).
- hrdata_o = 0 in every cycle other than a read ST_DATA.
- Array contents are not reset.

## Timing
- Reset values: hready_o=1, hresp_o=OKAY, hrdata_o=0, state ST_IDLE, counter 0, registered address/control 0. Reset mid-transfer aborts it; a write in ST_WAIT never reaches the array.
- OKAY latency: address accepted at edge N; hready_o=1 in cycle N+1+WAIT_STATES.
- ERROR: exactly two data-phase cycles, independent of WAIT_STATES.
- Read-after-write to same word in consecutive transfers (any WAIT_STATES incl. 0) returns the new data; array read is combinational from the registered index, or a write-forward path is provided.
- Master holds address/control while hready_o=0; slave ignores address inputs then.

## Structure
- Shared package vect_pkg gains: htrans_e, hresp_e, hsize encodings, ahb_slv_state_t, and function byte_strobe(hsize, addr[1:0]) returning 4-bit strobes.
- One sub-module natural: vmem_sram_array (MEM_WORDS × DATA_WIDTH, byte write enables, async read), so a hard macro can replace it.

## Test plan
- WAIT_STATES=1, word write 0xDEADBEEF to 0x10, then read 0x10 → hready_o low one cycle each, read returns 0xDEADBEEF, hresp_o=00.
- Byte write 0xAA to 0x13 over word 0x11223344 → read 0x10 returns 0xAA223344.
- Back-to-back NONSEQ reads 0x0,0x4,0x8 with WAIT_STATES=0 → one word per cycle, hready_o constantly 1.
- Access to BASE_ADDR+MEM_WORDS*4 and halfword at 0x1 → each gives hready_o=0/ERROR then hready_o=1/ERROR; memory unchanged.
- htrans_i=IDLE with hsel_i=1 → hready_o=1, hresp_o=00, no write.
- Assert resetn_i low during ST_WAIT of a write to 0x20 → outputs return to reset values asynchronously; later read of 0x20 returns pre-existing data.

Source files
------------

// File: rtl/vect_pkg.sv
// Shared vector-unit types: AHB-Lite encodings, slave FSM states and
// the byte-strobe helper used by the vector data memory.
package vect_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_slv_state_t;

    // Byte lanes touched by a transfer; anything wider than a
    // halfword is treated as a full word.
    function automatic logic [3:0] byte_strobe(
        input logic [2:0] hsize,
        input logic [1:0] addr
    );
        logic [3:0] s;
        s = 4'b0000;
        unique case (1'b1)
            (hsize == HSIZE_BYTE): s = 4'b0001 << addr;
            (hsize == HSIZE_HALF): s = addr[1] ? 4'b1100 : 4'b0011;
            default:               s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/vmem_sram_array.sv
// Word-organised SRAM with per-byte write enables and async read.
// Ports: clk_i, we_i, be_i (byte enables), addr_i, wdata_i, rdata_o.
module vmem_sram_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [DATA_WIDTH/8-1:0]      be_i,
    input  logic [$clog2(MEM_WORDS)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/vmem_ahb_slave.sv
// AHB-Lite subordinate in front of the vector data SRAM.
// Ports: clk_i, resetn_i, AHB slave side (hsel_i, haddr_i, htrans_i,
// hwrite_i, hsize_i, hwdata_i, hrdata_o, hready_o, hresp_o).
module vmem_ahb_slave #(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          MEM_WORDS   = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned          WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  hsel_i,
    input  logic [DATA_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hready_o,
    output logic [1:0]            hresp_o
);

    import vect_pkg::*;

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(MEM_WORDS * 4);
    localparam logic [2:0] WS_M1 = 3'(WAIT_STATES - 1);

    ahb_slv_state_t state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic             wr_q;
    logic [3:0]       strb_q;

    htrans_e               trans;
    logic [DATA_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx_d;
    logic                  misalign;
    logic                  out_rng;
    logic                  bad;
    logic                  rdy;
    logic                  accept;
    logic                  mem_we;
    logic                  rd_en;
    hresp_e                resp;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Ready depends only on state so accept has no loop through the FSM.
    assign rdy = (state_q != ST_WAIT) && (state_q != ST_ERR1);

    assign trans  = htrans_e'(htrans_i);
    assign accept = hsel_i && rdy &&
                    (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

    // Addresses below BASE_ADDR wrap to a huge offset and fail the
    // range check as well.
    assign offset  = haddr_i - BASE_ADDR;
    assign out_rng = offset >= SPAN;
    assign idx_d   = offset[IDX_W+1:2];

    always_comb begin
        misalign = 1'b0;
        unique case (1'b1)
            (hsize_i == HSIZE_BYTE): misalign = 1'b0;
            (hsize_i == HSIZE_HALF): misalign = haddr_i[0];
            default:                 misalign = |haddr_i[1:0];
        endcase
    end

    assign bad = out_rng || misalign;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q  <= idx_d;
                wr_q   <= hwrite_i;
                strb_q <= byte_strobe(hsize_i, haddr_i[1:0]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp    = HRESP_OKAY;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                resp    = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state_q == ST_DATA) begin
                    mem_we = wr_q;
                    rd_en  = !wr_q;
                end
                if (state_q == ST_ERR2) begin
                    resp = HRESP_ERROR;
                end
                state_d = ST_IDLE;
                if (accept) begin
                    if (bad) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_M1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    vmem_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .be_i    (NB'(strb_q)),
        .addr_i  (idx_q),
        .wdata_i (hwdata_i),
        .rdata_o (mem_rdata)
    );

    assign hrdata_o = rd_en ? mem_rdata : '0;
    assign hready_o = rdy;
    assign hresp_o  = resp;

endmodule
